// File: rtl/seq_pattern_detector_pkg.sv
// rtl/seq_pattern_detector_pkg.sv - shared state encodings and widths for the pattern detector
package seq_det_pkg;

  localparam logic [1:0] TRACK   = 2'b00;
  localparam logic [1:0] DELAY   = 2'b01;
  localparam logic [1:0] SUCCESS = 2'b11;

  localparam int TIMER_W = 8;

endpackage

// File: rtl/seq_pattern_detector_if.sv
// rtl/seq_pattern_detector_if.sv - serial input and status/counter bundle of the pattern detector
interface seq_pattern_detector_if #(
  parameter int COUNT_W = 6
);
  logic               input_valid;
  logic               sequential_input;
  logic               clear_count;
  logic [1:0]         current_state;
  logic               success_output;
  logic [COUNT_W-1:0] match_count;
  logic [COUNT_W-1:0] count_z;
  logic               overrun;

  // bit source / control side
  modport master (
    output input_valid, sequential_input, clear_count,
    input  current_state, success_output, match_count, count_z, overrun
  );

  // detector side
  modport slave (
    input  input_valid, sequential_input, clear_count,
    output current_state, success_output, match_count, count_z, overrun
  );
endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// rtl/seq_pattern_detector_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // clear beats increment; increment stops at all-ones instead of wrapping
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - parametrised serial bit-pattern detector with delayed success pulse
module seq_pattern_detector #(
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b111,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     DELAY       = 2,
  parameter int                     COUNT_W     = 6
) (
  input logic                   clock,
  input logic                   reset,
  seq_pattern_detector_if.slave bus
);
  import seq_det_pkg::TRACK;
  import seq_det_pkg::SUCCESS;
  import seq_det_pkg::TIMER_W;

  localparam int                FILL_W   = $clog2(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [1:0]             state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   overrun_q, overrun_d;

  logic                   accept;
  logic [PATTERN_LEN-1:0] window;
  logic                   match;
  logic [COUNT_W-1:0]     match_cnt;
  logic [COUNT_W-1:0]     zero_cnt;

  assign accept = bus.input_valid;
  assign window = {hist_q, bus.sequential_input};
  assign match  = accept && (fill_q == FILL_MAX) && (window == PATTERN);

  // shift history on accepted bits; fill tracks how many bits are valid, reset by a non-overlapping match
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (accept) begin
      hist_d = window[PATTERN_LEN-2:0];
      if (match && !OVERLAP) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // TRACK -> (DELAY for DELAY cycles) -> SUCCESS for one cycle; matches outside TRACK never restart it
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      TRACK: begin
        if (match) begin
          if (DELAY == 0) begin
            state_d = SUCCESS;
          end else begin
            state_d = seq_det_pkg::DELAY;
            timer_d = TIMER_W'(DELAY - 1);
          end
        end
      end
      seq_det_pkg::DELAY: begin
        if (timer_q == '0) begin
          state_d = SUCCESS;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = TRACK;
    endcase
  end

  // sticky flag for matches that arrive while a sequence is still in flight
  always_comb begin
    overrun_d = overrun_q;
    if (bus.clear_count) begin
      overrun_d = 1'b0;
    end else if (match && (state_q != TRACK)) begin
      overrun_d = 1'b1;
    end
  end

  // state registers; clear_count deliberately leaves the FSM alone
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      state_q   <= TRACK;
      timer_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      overrun_q <= overrun_d;
    end
  end

  sat_counter #(.W(COUNT_W)) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (bus.clear_count),
    .inc   (match),
    .q     (match_cnt)
  );

  sat_counter #(.W(COUNT_W)) u_zero_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (bus.clear_count),
    .inc   (accept && !bus.sequential_input),
    .q     (zero_cnt)
  );

  assign bus.current_state  = state_q;
  assign bus.success_output = (state_q == SUCCESS);
  assign bus.match_count    = match_cnt;
  assign bus.count_z        = zero_cnt;
  assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed vector bench for seq_pattern_detector
module tb_seq_pattern_detector;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.COUNT_W(6)) bus_a ();
  seq_pattern_detector_if #(.COUNT_W(6)) bus_b ();
  seq_pattern_detector_if #(.COUNT_W(3)) bus_c ();

  seq_pattern_detector u_a (.clock(clk), .reset(rst_a), .bus(bus_a));
  seq_pattern_detector #(.OVERLAP(1'b0), .DELAY(0)) u_b (.clock(clk), .reset(rst_b), .bus(bus_b));
  seq_pattern_detector #(.COUNT_W(3)) u_c (.clock(clk), .reset(rst_c), .bus(bus_c));

  typedef struct {
    logic       rst, vld, din, clr;
    logic [1:0] st;
    logic       succ;
    logic [5:0] mc, cz;
    logic       ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic v, logic d, logic c,
                              logic [1:0] s, logic sc, int m, int z, logic o);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d; t.clr = c;
    t.st = s; t.succ = sc; t.mc = 6'(m); t.cz = 6'(z); t.ovr = o;
    vecs.push_back(t);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step_a(logic r, logic v, logic d, logic c);
    rst_a = r; bus_a.input_valid = v; bus_a.sequential_input = d; bus_a.clear_count = c;
    @(posedge clk); #1;
  endtask

  task automatic step_b(logic r, logic v, logic d);
    rst_b = r; bus_b.input_valid = v; bus_b.sequential_input = d; bus_b.clear_count = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic step_c(logic r, logic v, logic d, logic c);
    rst_c = r; bus_c.input_valid = v; bus_c.sequential_input = d; bus_c.clear_count = c;
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_i;
    logic [5:0] exp_b_succ;
    // vectors: rst vld din clr | state succ match_count count_z overrun
    // 0,0,0,1,1,1 with default DELAY=2
    add(0,1,0,0, 2'd0,0,0,1,0);
    add(0,1,0,0, 2'd0,0,0,2,0);
    add(0,1,0,0, 2'd0,0,0,3,0);
    add(0,1,1,0, 2'd0,0,0,3,0);
    add(0,1,1,0, 2'd0,0,0,3,0);
    add(0,1,1,0, 2'd1,0,1,3,0);
    add(0,0,0,0, 2'd1,0,1,3,0);
    add(0,0,0,0, 2'd3,1,1,3,0);
    add(0,0,0,0, 2'd0,0,1,3,0);
    // five 1s: three matches, one pulse, overrun
    add(1,0,0,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd1,0,1,0,0);
    add(0,1,1,0, 2'd1,0,2,0,1);
    add(0,1,1,0, 2'd3,1,3,0,1);
    add(0,0,0,0, 2'd0,0,3,0,1);
    add(0,0,0,1, 2'd0,0,0,0,0);
    // 1,1, four invalid cycles with din=0, then 1
    add(1,0,0,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    for (int k = 0; k < 4; k++) add(0,0,0,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd1,0,1,0,0);
    add(0,0,0,0, 2'd1,0,1,0,0);
    add(0,0,0,0, 2'd3,1,1,0,0);
    add(0,0,0,0, 2'd0,0,1,0,0);
    // reset for one edge while in DELAY
    add(1,0,0,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd1,0,1,0,0);
    add(1,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd1,0,1,0,0);
    add(0,0,0,0, 2'd1,0,1,0,0);
    add(0,0,0,0, 2'd3,1,1,0,0);
    add(0,0,0,0, 2'd0,0,1,0,0);
    // clear_count coincident with a match: count cleared, pulse still comes
    add(1,0,0,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,0, 2'd0,0,0,0,0);
    add(0,1,1,1, 2'd1,0,0,0,0);
    add(0,0,0,0, 2'd1,0,0,0,0);
    add(0,0,0,0, 2'd3,1,0,0,0);
    add(0,0,0,0, 2'd0,0,0,0,0);

    bus_a.input_valid = 0; bus_a.sequential_input = 0; bus_a.clear_count = 0;
    bus_b.input_valid = 0; bus_b.sequential_input = 0; bus_b.clear_count = 0;
    bus_c.input_valid = 0; bus_c.sequential_input = 0; bus_c.clear_count = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_a = 0; rst_b = 0; rst_c = 0;

    // state right after reset
    check("rst_a_state", 32'(bus_a.current_state), 0);
    check("rst_a_succ", 32'(bus_a.success_output), 0);
    check("rst_a_mc", 32'(bus_a.match_count), 0);
    check("rst_a_cz", 32'(bus_a.count_z), 0);
    check("rst_a_ovr", 32'(bus_a.overrun), 0);
    check("rst_b_state", 32'(bus_b.current_state), 0);
    check("rst_c_mc", 32'(bus_c.match_count), 0);

    // table-driven run on the default instance
    foreach (vecs[i]) begin
      step_a(vecs[i].rst, vecs[i].vld, vecs[i].din, vecs[i].clr);
      check($sformatf("v%0d_state", i), 32'(bus_a.current_state), 32'(vecs[i].st));
      check($sformatf("v%0d_succ", i), 32'(bus_a.success_output), 32'(vecs[i].succ));
      check($sformatf("v%0d_mc", i), 32'(bus_a.match_count), 32'(vecs[i].mc));
      check($sformatf("v%0d_cz", i), 32'(bus_a.count_z), 32'(vecs[i].cz));
      check($sformatf("v%0d_ovr", i), 32'(bus_a.overrun), 32'(vecs[i].ovr));
    end

    // non-overlap, zero delay: six 1s match on bits 3 and 6, pulse right after each
    exp_b_succ = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      step_b(0, 1, 1);
      check($sformatf("b%0d_succ", i), 32'(bus_b.success_output), 32'(exp_b_succ[i]));
      check($sformatf("b%0d_state", i), 32'(bus_b.current_state), exp_b_succ[i] ? 32'd3 : 32'd0);
    end
    step_b(0, 0, 0);
    check("b_idle_succ", 32'(bus_b.success_output), 0);
    check("b_mc", 32'(bus_b.match_count), 2);
    check("b_ovr", 32'(bus_b.overrun), 0);

    // 3-bit counters: count_z saturates at 7
    for (int i = 0; i < 10; i++) begin
      step_c(0, 1, 0, 0);
      exp_i = (i + 1 > 7) ? 7 : i + 1;
      check($sformatf("c_cz%0d", i), 32'(bus_c.count_z), 32'(exp_i));
    end
    step_c(0, 0, 0, 1);
    check("c_cz_clr", 32'(bus_c.count_z), 0);
    // ten 1s: eight matches, match_count stops at 7
    for (int i = 0; i < 10; i++) begin
      step_c(0, 1, 1, 0);
      exp_i = (i < 2) ? 0 : ((i - 1 > 7) ? 7 : i - 1);
      check($sformatf("c_mc%0d", i), 32'(bus_c.match_count), 32'(exp_i));
    end
    check("c_ovr", 32'(bus_c.overrun), 1);
    check("c_cz_hold", 32'(bus_c.count_z), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
